// File: rtl/if_redirect_ctrl_pkg.sv
// rtl/if_redirect_ctrl_pkg.sv - shared types and constants for the fetch redirect controller
package if_redirect_ctrl_pkg;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
  localparam logic [31:0] EXC_PC   = 32'hbfc0_0380;
  localparam logic [31:0] STEP     = 32'd8;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_WAIT_JR = 2'd2
  } state_e;

  // Numerically larger kind wins, so priority compare is a plain magnitude compare.
  typedef enum logic [2:0] {
    EV_NONE = 3'd0,
    EV_CLN  = 3'd1,
    EV_BR2  = 3'd2,
    EV_BR1  = 3'd3,
    EV_INT  = 3'd4
  } ev_kind_e;

  typedef struct packed {
    ev_kind_e    kind;
    logic        jr;
    logic [31:0] tgt;
  } redir_ev_t;

  localparam redir_ev_t EV_IDLE = '{kind: EV_NONE, jr: 1'b0, tgt: 32'h0};

  function automatic logic ev_beats(input ev_kind_e a, input ev_kind_e b);
    return a > b;
  endfunction

endpackage

// File: rtl/if_redirect_pend.sv
// rtl/if_redirect_pend.sv - pending redirect event register with priority capture and jr target cache
module if_redirect_pend
  import if_redirect_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        int_i,
  input  logic        branch_1_i,
  input  logic        branch_2_i,
  input  logic        jr_i,
  input  logic        if_cln_i,
  input  logic [31:0] tgt_1_i,
  input  logic [31:0] tgt_2_i,
  input  logic [31:0] jr_data_i,
  input  logic        jr_data_ok_i,
  input  logic        capture_i,
  input  logic        clear_i,
  input  logic        set_jr_i,
  input  logic        cache_clr_i,
  output redir_ev_t   eff_o,
  output logic        pend_valid_o,
  output logic        cache_valid_o,
  output logic [31:0] cache_data_o
);

  redir_ev_t   live;
  redir_ev_t   pend_q, pend_d;
  logic        cache_valid_q, cache_valid_d;
  logic [31:0] cache_data_q, cache_data_d;

  always_comb begin
    live = EV_IDLE;
    if (int_i) begin
      live.kind = EV_INT;
    end else if (branch_1_i) begin
      live.kind = EV_BR1;
      live.jr   = jr_i;
      live.tgt  = tgt_1_i;
    end else if (branch_2_i) begin
      live.kind = EV_BR2;
      live.jr   = jr_i;
      live.tgt  = tgt_2_i;
    end else if (if_cln_i) begin
      live.kind = EV_CLN;
    end
  end

  // On a tie the older pending event is kept.
  assign eff_o        = ev_beats(live.kind, pend_q.kind) ? live : pend_q;
  assign pend_valid_o = (pend_q.kind != EV_NONE);

  always_comb begin
    pend_d = pend_q;
    if (clear_i) begin
      pend_d = EV_IDLE;
    end else if (set_jr_i) begin
      pend_d = '{kind: EV_BR1, jr: 1'b1, tgt: 32'h0};
    end else if (capture_i && ev_beats(live.kind, pend_q.kind)) begin
      pend_d = live;
    end
  end

  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_data_d  = cache_data_q;
    if (cache_clr_i) begin
      cache_valid_d = 1'b0;
    end else if (jr_data_ok_i) begin
      cache_valid_d = 1'b1;
      cache_data_d  = jr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q        <= EV_IDLE;
      cache_valid_q <= 1'b0;
      cache_data_q  <= 32'h0;
    end else begin
      pend_q        <= pend_d;
      cache_valid_q <= cache_valid_d;
      cache_data_q  <= cache_data_d;
    end
  end

  assign cache_valid_o = cache_valid_q;
  assign cache_data_o  = cache_data_q;

endmodule

// File: rtl/if_redirect_ctrl.sv
// rtl/if_redirect_ctrl.sv - fetch PC owner: sequential advance, stall hold and prioritised redirects
module if_redirect_ctrl
  import if_redirect_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        delay_hard_i,
  input  logic        delay_soft_i,
  input  logic        int_i,
  input  logic        branch_1_i,
  input  logic        branch_2_i,
  input  logic        jr_i,
  input  logic [31:0] tgt_1_i,
  input  logic [31:0] tgt_2_i,
  input  logic [31:0] jr_data_i,
  input  logic        jr_data_ok_i,
  input  logic        if_cln_i,
  output logic [31:0] pc_o,
  output logic        pcn_o,
  output logic        flush_o,
  output logic        busy_o
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pcn_q, pcn_d;

  logic        stall;
  logic        pend_capture, pend_clear, pend_set_jr, cache_clr;
  redir_ev_t   eff;
  logic        pend_valid;
  logic        cache_valid;
  logic [31:0] cache_data;

  assign stall = delay_hard_i | delay_soft_i;

  if_redirect_pend u_pend (
    .clk_i        (clk_i),
    .rst_i        (reset_i),
    .int_i        (int_i),
    .branch_1_i   (branch_1_i),
    .branch_2_i   (branch_2_i),
    .jr_i         (jr_i),
    .if_cln_i     (if_cln_i),
    .tgt_1_i      (tgt_1_i),
    .tgt_2_i      (tgt_2_i),
    .jr_data_i    (jr_data_i),
    .jr_data_ok_i (jr_data_ok_i),
    .capture_i    (pend_capture),
    .clear_i      (pend_clear),
    .set_jr_i     (pend_set_jr),
    .cache_clr_i  (cache_clr),
    .eff_o        (eff),
    .pend_valid_o (pend_valid),
    .cache_valid_o(cache_valid),
    .cache_data_o (cache_data)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      pcn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pcn_q   <= pcn_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pcn_d        = 1'b0;
    pend_capture = 1'b0;
    pend_clear   = 1'b0;
    pend_set_jr  = 1'b0;
    cache_clr    = 1'b0;
    case (state_q)
      ST_RUN, ST_HOLD: begin
        if (stall) begin
          state_d      = ST_HOLD;
          pend_capture = 1'b1;
        end else begin
          state_d    = ST_RUN;
          pend_clear = 1'b1;
          case (eff.kind)
            EV_INT: begin
              pc_d      = EXC_PC;
              pcn_d     = 1'b1;
              cache_clr = 1'b1;
            end
            EV_BR1, EV_BR2: begin
              if (!eff.jr) begin
                pc_d  = eff.tgt;
                pcn_d = 1'b1;
              end else if (jr_data_ok_i) begin
                pc_d      = jr_data_i;
                pcn_d     = 1'b1;
                cache_clr = 1'b1;
              end else if (cache_valid) begin
                pc_d      = cache_data;
                pcn_d     = 1'b1;
                cache_clr = 1'b1;
              end else begin
                state_d = ST_WAIT_JR;
              end
            end
            default: begin
              pc_d  = pc_q + STEP;
              pcn_d = 1'b1;
            end
          endcase
        end
      end
      ST_WAIT_JR: begin
        if (int_i) begin
          state_d   = ST_RUN;
          pc_d      = EXC_PC;
          pcn_d     = 1'b1;
          cache_clr = 1'b1;
        end else if (jr_data_ok_i) begin
          // A target landing during a stall is parked in the cache as a pending jr.
          if (stall) begin
            state_d     = ST_HOLD;
            pend_set_jr = 1'b1;
          end else begin
            state_d   = ST_RUN;
            pc_d      = jr_data_i;
            pcn_d     = 1'b1;
            cache_clr = 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    flush_o = 1'b0;
    case (state_q)
      ST_RUN, ST_HOLD: flush_o = stall ? delay_soft_i : (eff.kind != EV_NONE);
      ST_WAIT_JR:      flush_o = 1'b1;
      default:         flush_o = 1'b0;
    endcase
    busy_o = (state_q == ST_WAIT_JR) || pend_valid;
  end

  assign pc_o  = pc_q;
  assign pcn_o = pcn_q;

endmodule

// File: doc/if_redirect_ctrl.md
# if_redirect_ctrl

Fetch-redirect controller for the dual-issue IF stage. It owns the fetch PC register and decides, each cycle, whether fetch advances sequentially (+8), holds for a stall, or redirects to an exception vector, a branch/jump target or a jr register target. Redirect requests that arrive during a stall are held pending and prioritised. The controller tells the IF/ID register when to flush and when the fetch PC is valid.

## Interface
- RESET_PC, 32'hbfc0_0000, fetch PC after reset
- EXC_PC, 32'hbfc0_0380, interrupt/exception vector
- STEP, 8, sequential fetch increment (two instructions per fetch)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- delay_hard  in  1  hard stall: hold PC, do not flush
- delay_soft  in  1  soft stall: hold PC, ID receives bubble (flush asserted)
- int  in  1  interrupt/exception request, single-cycle pulse
- branch_1  in  1  taken redirect resolved from issue slot 1
- branch_2  in  1  taken redirect resolved from issue slot 2
- jr  in  1  qualifies the concurrent branch_1/branch_2 as a register jump
- tgt_1  in  32  branch/j target for slot 1 (computed upstream)
- tgt_2  in  32  branch/j target for slot 2
- jr_data  in  32  jr register value
- jr_data_ok  in  1  jr_data valid this cycle
- if_cln  in  1  pipeline clean request (flush only, no redirect)
- pc  out  32  current fetch PC (registered)
- pcn  out  1  pc valid / new fetch issued this cycle
- flush  out  1  clear IF/ID instruction and pc this cycle
- busy  out  1  redirect pending or waiting on jr data

## Operation
- States: RUN, HOLD (stalled, possibly with pending event), WAIT_JR (jr redirect accepted, target unknown).
- Event priority: int > branch_1 > branch_2 > if_cln. Pending register holds kind {NONE, INT, BR1, BR2, CLN}, jr flag, captured target.
- stall = delay_hard | delay_soft. In RUN with stall: go HOLD; capture live event into pending if its priority exceeds pending's; otherwise keep pending. int always overwrites.
- In RUN/HOLD without stall: effective event = higher of pending and live. Actions:
  - INT: pc<=EXC_PC, pcn=1, flush=1, pending cleared, jr cache cleared.
  - BR1/BR2 non-jr: pc<=captured/live tgt_1/tgt_2, pcn=1, flush=1.
  - BR1/BR2 jr: if jr_data_ok, pc<=jr_data; else if jr cache valid, pc<=cache; else go WAIT_JR, pcn=0, flush=1.
  - CLN: pc<=pc+STEP, flush=1.
  - NONE: pc<=pc+STEP, pcn=1, flush=0.
- HOLD: pc held, pcn=0; flush=delay_soft; return to RUN when stall drops (action above applied same edge).
- WAIT_JR: pc held, pcn=0, busy=1; on jr_data_ok: pc<=jr_data, pcn=1, go RUN. int in WAIT_JR aborts: pc<=EXC_PC. Stall in WAIT_JR is ignored until target arrives, then behaves as HOLD.
- jr cache: loaded whenever jr_data_ok=1; valid cleared when consumed or on INT.
- Arithmetic: pc+STEP modulo 2^32, wrap at 32'hffff_fff8 -> 0 without flag.

## Timing
- Reset values: pc=RESET_PC, pcn=1, flush=0, busy=0, state RUN, pending NONE, cache invalid.
- All outputs registered except flush and busy, which are decoded from state/inputs in the same cycle (combinational, no input-to-pc path).
- Redirect latency: event sampled at edge N, new pc visible after edge N (1 cycle). Pending event applied the edge stall deasserts.
- Simultaneous branch_1 and branch_2: branch_1 wins, branch_2 dropped. int with any branch: int wins, branch dropped.
- Reset mid-WAIT_JR or HOLD: immediate return to reset values, pending discarded.

## Structure
- Shared package: state enum, event-kind enum, RESET_PC/EXC_PC constants.
- One sub-module natural: if_redirect_pend (pending-event capture with priority compare and jr cache).

## Test plan
- Reset release, 3 idle cycles -> pc 0xbfc00000, 0xbfc00008, 0xbfc00010, pcn=1, flush=0.
- branch_2 tgt_2=0xbfc00100 while delay_hard 2 cycles -> pc held, pcn=0; edge after stall drop pc=0xbfc00100, flush=1.
- branch_2 during stall then int next stall cycle -> pc=0xbfc00380 after release, branch dropped.
- branch_1+jr with jr_data_ok=0 -> WAIT_JR, busy=1 for 3 cycles; jr_data_ok with 0x80001234 -> pc=0x80001234, pcn=1.
- branch_1 tgt_1=0x100 and branch_2 tgt_2=0x200 same cycle -> pc=0x100.
- reset asserted during WAIT_JR -> pc=0xbfc00000, busy=0 immediately.
